cnn_layer_accel_awe_stride_ctrl: RTL and testbench

- Layer-level sequencer for strided pixel selection in the AWE input path.
- Accepts a per-layer configuration (stride, frame columns, frame rows), then walks one raster-order input frame.
- Forwards only pixels whose row and column are both multiples of the stride; all other pixels are consumed and dropped.
- Drives valid/ready handshakes on both sides, tags row/frame boundaries on output, and pulses done at frame end.

---
 rtl/cnn_layer_accel_awe_stride_ctrl.sv | 164 ++++++++++++++++
 tb/tb_cnn_layer_accel_awe_stride_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_layer_accel_awe_stride_ctrl.sv
// Layer-level stride sequencer for the AWE input path: walks one raster frame
// and forwards only pixels on the stride grid, tagging row/frame ends.
//
// state | meaning
// IDLE  | waiting for a per-layer configuration
// ARMED | configuration latched, waiting for start
// RUN   | consuming the input frame, forwarding stride-grid pixels
// DRAIN | input done, waiting for the output register to empty
module cnn_layer_accel_awe_stride_ctrl #(
  parameter int C_DATAIN_WIDTH = 16,
  parameter int C_MAX_STRIDE   = 8,
  parameter int C_DIM_WIDTH    = 10,
  parameter int C_STRIDE_WIDTH = $clog2(C_MAX_STRIDE) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [C_STRIDE_WIDTH-1:0] cfg_stride,
  input  logic [C_DIM_WIDTH-1:0]    cfg_num_cols,
  input  logic [C_DIM_WIDTH-1:0]    cfg_num_rows,
  output logic                      cfg_err,
  input  logic                      start,
  output logic                      busy,
  input  logic [C_DATAIN_WIDTH-1:0] datain,
  input  logic                      datain_valid,
  output logic                      datain_ready,
  output logic [C_DATAIN_WIDTH-1:0] dataout,
  output logic                      dataout_valid,
  input  logic                      dataout_ready,
  output logic                      dataout_eol,
  output logic                      dataout_eof,
  output logic                      done
);

  typedef enum logic [1:0] {IDLE, ARMED, RUN, DRAIN} state_t;

  localparam logic [C_STRIDE_WIDTH-1:0] MAX_STRIDE = C_STRIDE_WIDTH'(C_MAX_STRIDE);
  localparam logic [C_STRIDE_WIDTH-1:0] ONE_S      = C_STRIDE_WIDTH'(1);
  localparam logic [C_DIM_WIDTH-1:0]    ONE_D      = C_DIM_WIDTH'(1);

  state_t                    state;
  logic [C_STRIDE_WIDTH-1:0] stride;
  logic [C_DIM_WIDTH-1:0]    num_cols;
  logic [C_DIM_WIDTH-1:0]    num_rows;
  logic [C_DIM_WIDTH-1:0]    col;
  logic [C_DIM_WIDTH-1:0]    row;
  logic [C_STRIDE_WIDTH-1:0] col_phase;
  logic [C_STRIDE_WIDTH-1:0] row_phase;

  logic                      cfg_bad;
  logic                      out_free;
  logic                      xfer;
  logic                      keep;
  logic                      last_col;
  logic                      last_row;
  logic                      eol_next;
  logic                      eof_next;
  logic [C_DIM_WIDTH:0]      stride_ext;
  logic [C_DIM_WIDTH:0]      col_plus_s;
  logic [C_DIM_WIDTH:0]      row_plus_s;
  logic [C_STRIDE_WIDTH-1:0] stride_m1;

  assign cfg_bad = (cfg_stride == '0) || (cfg_stride > MAX_STRIDE) ||
                   (cfg_num_cols == '0) || (cfg_num_rows == '0);

  assign cfg_ready    = (state == IDLE) && !rst;
  assign busy         = (state != IDLE);
  assign out_free     = !dataout_valid || dataout_ready;
  assign datain_ready = (state == RUN) && out_free;
  assign xfer         = datain_valid && datain_ready;
  assign keep         = (col_phase == '0) && (row_phase == '0);

  // One extra bit so col+s / row+s cannot wrap at the largest frame size.
  assign stride_ext = (C_DIM_WIDTH + 1)'(stride);
  assign col_plus_s = {1'b0, col} + stride_ext;
  assign row_plus_s = {1'b0, row} + stride_ext;
  assign eol_next   = (col_plus_s >= {1'b0, num_cols});
  assign eof_next   = eol_next && (row_plus_s >= {1'b0, num_rows});

  assign last_col  = (col == num_cols - ONE_D);
  assign last_row  = (row == num_rows - ONE_D);
  assign stride_m1 = stride - ONE_S;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      stride        <= '0;
      num_cols      <= '0;
      num_rows      <= '0;
      col           <= '0;
      row           <= '0;
      col_phase     <= '0;
      row_phase     <= '0;
      cfg_err       <= 1'b0;
      done          <= 1'b0;
      dataout       <= '0;
      dataout_valid <= 1'b0;
      dataout_eol   <= 1'b0;
      dataout_eof   <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      done    <= 1'b0;

      // A new kept pixel replaces the current one only when the register frees.
      if (xfer && keep) begin
        dataout       <= datain;
        dataout_valid <= 1'b1;
        dataout_eol   <= eol_next;
        dataout_eof   <= eof_next;
      end else if (dataout_ready) begin
        dataout_valid <= 1'b0;
        dataout_eol   <= 1'b0;
        dataout_eof   <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (cfg_valid) begin
            if (cfg_bad) begin
              cfg_err <= 1'b1;
            end else begin
              stride   <= cfg_stride;
              num_cols <= cfg_num_cols;
              num_rows <= cfg_num_rows;
              state    <= ARMED;
            end
          end
        end
        ARMED: begin
          if (start) begin
            col       <= '0;
            row       <= '0;
            col_phase <= '0;
            row_phase <= '0;
            state     <= RUN;
          end
        end
        RUN: begin
          if (xfer) begin
            if (last_col) begin
              col       <= '0;
              col_phase <= '0;
              row       <= row + ONE_D;
              row_phase <= (row_phase == stride_m1) ? '0 : row_phase + ONE_S;
              if (last_row) state <= DRAIN;
            end else begin
              col       <= col + ONE_D;
              col_phase <= (col_phase == stride_m1) ? '0 : col_phase + ONE_S;
            end
          end
        end
        DRAIN: begin
          if (out_free) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_layer_accel_awe_stride_ctrl.sv
// Directed bench for the stride sequencer: hand-computed output streams,
// flags, done timing, backpressure, illegal configs and mid-frame reset.
module tb_cnn_layer_accel_awe_stride_ctrl;
  localparam int DW = 16;
  localparam int SW = 4;
  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [SW-1:0] cfg_stride;
  logic [CW-1:0] cfg_num_cols;
  logic [CW-1:0] cfg_num_rows;
  logic          cfg_err;
  logic          start;
  logic          busy;
  logic [DW-1:0] datain;
  logic          datain_valid;
  logic          datain_ready;
  logic [DW-1:0] dataout;
  logic          dataout_valid;
  logic          dataout_ready;
  logic          dataout_eol;
  logic          dataout_eof;
  logic          done;

  cnn_layer_accel_awe_stride_ctrl dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_stride(cfg_stride),
    .cfg_num_cols(cfg_num_cols), .cfg_num_rows(cfg_num_rows), .cfg_err(cfg_err),
    .start(start), .busy(busy),
    .datain(datain), .datain_valid(datain_valid), .datain_ready(datain_ready),
    .dataout(dataout), .dataout_valid(dataout_valid), .dataout_ready(dataout_ready),
    .dataout_eol(dataout_eol), .dataout_eof(dataout_eof), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  logic [DW-1:0] oq[$];
  bit            eolq[$];
  bit            eofq[$];
  int            ocyc[$];
  int            done_cnt;
  int            done_cyc;
  int            last_xfer;
  int            first_xfer;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_cfg(input int s, input int w, input int h);
    @(negedge clk);
    cfg_valid    = 1'b1;
    cfg_stride   = SW'(s);
    cfg_num_cols = CW'(w);
    cfg_num_rows = CW'(h);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Feeds base..base+n-1; optionally toggles dataout_ready; collects outputs.
  task automatic run_stream(input int base, input int n, input bit toggle,
                            input bit wait_done, input int budget);
    int            idx = 0;
    int            cyc = 0;
    bit            stalled = 1'b0;
    bit            finished = 1'b0;
    logic [DW-1:0] held = '0;
    oq.delete(); eolq.delete(); eofq.delete(); ocyc.delete();
    done_cnt = 0; done_cyc = -1; last_xfer = -1; first_xfer = -1;
    while (!finished && cyc < budget) begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        finished = 1'b1;
      end
      if (stalled) chk("stall_hold", dataout, held);
      if (!finished) begin
        dataout_ready = toggle ? (cyc % 2 == 0) : 1'b1;
        datain_valid  = (idx < n);
        datain        = DW'(base + idx);
        #1;
        stalled = dataout_valid && !dataout_ready;
        held    = dataout;
        if (stalled) chk("stall_in_ready", datain_ready, 0);
        if (dataout_valid && dataout_ready) begin
          oq.push_back(dataout);
          eolq.push_back(dataout_eol);
          eofq.push_back(dataout_eof);
          ocyc.push_back(cyc);
        end
        if (datain_valid && datain_ready) begin
          if (first_xfer < 0) first_xfer = cyc;
          last_xfer = cyc;
          idx++;
        end
        if (!wait_done && idx == n) finished = 1'b1;
        cyc++;
      end
    end
    datain_valid  = 1'b0;
    dataout_ready = 1'b1;
    chk("stream_complete", finished, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_stride = '0; cfg_num_cols = '0; cfg_num_rows = '0;
    start = 1'b0; datain = '0; datain_valid = 1'b0; dataout_ready = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_cfg_ready", cfg_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dataout", dataout, 0);
    chk("rst_valid", dataout_valid, 0);
    chk("rst_in_ready", datain_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_cfg_ready", cfg_ready, 1);
    chk("idle_done", done, 0);

    // s=2 W=4 H=4 -> 0,2,8,10
    do_cfg(2, 4, 4);
    chk("t1_cfg_err", cfg_err, 0);
    chk("t1_armed_busy", busy, 1);
    chk("t1_armed_cfg_ready", cfg_ready, 0);
    do_start();
    run_stream(0, 16, 1'b0, 1'b1, 100);
    chk("t1_count", oq.size(), 4);
    chk("t1_d0", oq[0], 0);
    chk("t1_d1", oq[1], 2);
    chk("t1_d2", oq[2], 8);
    chk("t1_d3", oq[3], 10);
    chk("t1_eol", {eolq[0], eolq[1], eolq[2], eolq[3]}, 4'b0101);
    chk("t1_eof", {eofq[0], eofq[1], eofq[2], eofq[3]}, 4'b0001);
    chk("t1_done_timing", done_cyc - last_xfer, 2);
    chk("t1_done_count", done_cnt, 1);
    @(negedge clk);
    chk("t1_done_pulse", done, 0);
    chk("t1_idle", cfg_ready, 1);

    // s=1 W=3 H=2 -> all six, full throughput
    do_cfg(1, 3, 2);
    do_start();
    run_stream(10, 6, 1'b0, 1'b1, 100);
    chk("t2_count", oq.size(), 6);
    chk("t2_d0", oq[0], 10);
    chk("t2_d5", oq[5], 15);
    chk("t2_latency", ocyc[0] - first_xfer, 1);
    chk("t2_throughput", ocyc[5] - ocyc[0], 5);
    chk("t2_eol", {eolq[0], eolq[1], eolq[2], eolq[3], eolq[4], eolq[5]}, 6'b001001);
    chk("t2_eof", {eofq[0], eofq[1], eofq[2], eofq[3], eofq[4], eofq[5]}, 6'b000001);

    // s=2 W=5 H=3 -> 0,2,4,10,12,14
    do_cfg(2, 5, 3);
    do_start();
    run_stream(0, 15, 1'b0, 1'b1, 100);
    chk("t3_count", oq.size(), 6);
    chk("t3_d2", oq[2], 4);
    chk("t3_d3", oq[3], 10);
    chk("t3_d5", oq[5], 14);
    chk("t3_eol", {eolq[0], eolq[1], eolq[2], eolq[3], eolq[4], eolq[5]}, 6'b001001);
    chk("t3_eof", {eofq[0], eofq[1], eofq[2], eofq[3], eofq[4], eofq[5]}, 6'b000001);

    // s=2 W=4 H=4 with downstream toggling
    do_cfg(2, 4, 4);
    do_start();
    run_stream(0, 16, 1'b1, 1'b1, 200);
    chk("t4_count", oq.size(), 4);
    chk("t4_d0", oq[0], 0);
    chk("t4_d1", oq[1], 2);
    chk("t4_d2", oq[2], 8);
    chk("t4_d3", oq[3], 10);
    chk("t4_eof", eofq[3], 1);
    chk("t4_done_count", done_cnt, 1);

    // Illegal configs: s=0, s=9, W=0
    do_cfg(0, 4, 4);
    chk("bad_s0_err", cfg_err, 1);
    chk("bad_s0_ready", cfg_ready, 1);
    chk("bad_s0_busy", busy, 0);
    do_cfg(9, 4, 4);
    chk("bad_s9_err", cfg_err, 1);
    chk("bad_s9_busy", busy, 0);
    do_cfg(2, 0, 4);
    chk("bad_w0_err", cfg_err, 1);
    chk("bad_w0_ready", cfg_ready, 1);
    do_start();
    chk("bad_start_ignored", busy, 0);
    chk("bad_err_pulse", cfg_err, 0);

    // Mid-frame reset, then a fresh frame
    do_cfg(3, 6, 6);
    chk("t6_cfg_err", cfg_err, 0);
    do_start();
    run_stream(0, 10, 1'b0, 1'b0, 100);
    chk("t6_count", oq.size(), 2);
    chk("t6_d1", oq[1], 3);
    chk("t6_pre_busy", busy, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_dataout", dataout, 0);
    chk("t6_rst_valid", dataout_valid, 0);
    chk("t6_rst_eol_eof", {dataout_eol, dataout_eof}, 2'b00);
    chk("t6_rst_done", done, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_cfg_ready", cfg_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_post_cfg_ready", cfg_ready, 1);
    chk("t6_post_done", done, 0);
    do_cfg(1, 2, 1);
    do_start();
    run_stream(16'h55, 2, 1'b0, 1'b1, 100);
    chk("t6_new_count", oq.size(), 2);
    chk("t6_new_d0", oq[0], 16'h55);
    chk("t6_new_d1", oq[1], 16'h56);
    chk("t6_new_eof", {eofq[0], eofq[1]}, 2'b01);
    chk("t6_new_done", done_cnt, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
